// File: rtl/audio_scale_pkg.sv
// audio_scale_pkg
//   Shared types and default widths for the audio_scale_arbiter slice.
//   - state_t   : sequencing FSM states (IDLE, CAPTURE, SCALE, OUT)
//   - NCH       : number of requesting channels
//   - *_DEF     : default input width, output width and shift amount
package audio_scale_pkg;
    localparam int NCH       = 2;
    localparam int IN_W_DEF  = 16;
    localparam int OUT_W_DEF = 24;
    localparam int SHIFT_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        SCALE   = 2'd2,
        OUT     = 2'd3
    } state_t;
endpackage

// File: rtl/audio_widen_stage.sv
// audio_widen_stage
//   Registered sign-extend-and-shift. On load, dout takes
//   sign_extend(din, OUT_W) << SHIFT; on clr it returns to 0, otherwise holds.
//   Ports:
//     clk, rst   clock, asynchronous active-high reset (dout -> 0)
//     load       capture the widened din
//     clr        drive dout back to 0 (load wins if both are high)
//     din        IN_W-bit signed sample
//     dout       OUT_W-bit widened sample
module audio_widen_stage #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 24,
    parameter int SHIFT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clr,
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] dout
);
    logic signed [IN_W-1:0]  din_s;
    logic signed [OUT_W-1:0] ext;

    // Size cast of a signed operand replicates the sign bit.
    assign din_s = din;
    assign ext   = OUT_W'(din_s);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       dout <= '0;
        else if (load) dout <= ext << SHIFT;
        else if (clr)  dout <= '0;
    end
endmodule

// File: rtl/audio_scale_arbiter.sv
// audio_scale_arbiter
//   Round-robin sharing of one 16->24 bit sign-preserving widening stage
//   between two sample requesters. One sample is in flight at a time and is
//   sequenced IDLE -> CAPTURE -> SCALE -> OUT; every output is registered.
//   Ports:
//     clk, rst             clock, asynchronous active-high reset
//     en                   gates new grants only (in-flight sample completes)
//     in_valid[1:0]        per-channel request
//     in_data0, in_data1   signed samples, channel 0 / 1
//     in_ready[1:0]        one-hot accept strobe, high during CAPTURE
//     out_valid/out_ready  output handshake
//     out_data, out_chan   widened sample (0 when not valid) and its channel
//     busy                 high in any state other than IDLE
//     cnt0, cnt1           per-channel output handshake counters
//   Optional feature: define AUDIO_SCALE_STATS_EN to build cnt0/cnt1.
module audio_scale_arbiter
    import audio_scale_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int SHIFT = SHIFT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [NCH-1:0]   in_valid,
    input  logic [IN_W-1:0]  in_data0,
    input  logic [IN_W-1:0]  in_data1,
    output logic [NCH-1:0]   in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_chan,
    output logic             busy
`ifdef AUDIO_SCALE_STATS_EN
    ,
    output logic [15:0]      cnt0,
    output logic [15:0]      cnt1
`endif
);
    generate
        if (IN_W + SHIFT > OUT_W) begin : g_width_check
            $error("audio_scale_arbiter: IN_W + SHIFT must not exceed OUT_W");
        end
    endgenerate

    state_t          state;
    logic            grant;
    logic            last;
    logic [IN_W-1:0] hold;
    logic            req;
    logic            pick;
    logic            hs;

    assign req  = en && (|in_valid);
    // Tie goes to the channel not served last; a lone request wins outright.
    assign pick = (&in_valid) ? ~last : in_valid[1];
    assign hs   = (state == OUT) && out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= 1'b0;
            last      <= 1'b1;
            hold      <= '0;
            in_ready  <= '0;
            out_valid <= 1'b0;
            out_chan  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        grant    <= pick;
                        in_ready <= NCH'(1) << pick;
                        busy     <= 1'b1;
                        state    <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    hold     <= grant ? in_data1 : in_data0;
                    in_ready <= '0;
                    state    <= SCALE;
                end
                SCALE: begin
                    out_chan  <= grant;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        last      <= out_chan;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Loaded in SCALE so the result appears with out_valid; cleared on the
    // handshake so out_data reads 0 outside OUT.
    audio_widen_stage #(
        .IN_W (IN_W),
        .OUT_W(OUT_W),
        .SHIFT(SHIFT)
    ) u_widen (
        .clk (clk),
        .rst (rst),
        .load(state == SCALE),
        .clr (hs),
        .din (hold),
        .dout(out_data)
    );

`ifdef AUDIO_SCALE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (hs) begin
            if (out_chan) cnt1 <= cnt1 + 16'd1;
            else          cnt0 <= cnt0 + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_audio_scale_arbiter.sv
// tb_audio_scale_arbiter
//   Directed and randomized transactions on audio_scale_arbiter, checked
//   against a transaction-level model: grant = round-robin choice from the
//   request pattern, data = signed sample * 2^8 truncated to 24 bits.
module tb_audio_scale_arbiter;
    logic        clk = 1'b0;
    logic        rst, en, out_ready;
    logic [1:0]  in_valid, in_ready;
    logic [15:0] in_data0, in_data1;
    logic        out_valid, out_chan, busy;
    logic [23:0] out_data;
`ifdef AUDIO_SCALE_STATS_EN
    logic [15:0] cnt0, cnt1;
    logic [15:0] mcnt0, mcnt1;
`endif

    int          checks = 0;
    int          errors = 0;
    bit          mlast;
    logic        exp_g;
    logic [23:0] exp_d;

    always #5 clk = ~clk;

    audio_scale_arbiter dut (
        .clk(clk), .rst(rst), .en(en),
        .in_valid(in_valid), .in_data0(in_data0), .in_data1(in_data1),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_chan(out_chan), .busy(busy)
`ifdef AUDIO_SCALE_STATS_EN
        , .cnt0(cnt0), .cnt1(cnt1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] ref_widen(input logic [15:0] d);
        int v;
        v = int'($signed(d)) * 256;
        return v[23:0];
    endfunction

    function automatic logic ref_grant(input logic [1:0] v, input bit last_served);
        if (v == 2'b11) return ~last_served;
        return v[1];
    endfunction

    // Entered in IDLE just after an edge; leaves the DUT in OUT (cycle N+3).
    task automatic start_txn(input logic [1:0] v, input logic [15:0] d0,
                             input logic [15:0] d1, input bit drop_en);
        in_valid  = v;
        in_data0  = d0;
        in_data1  = d1;
        en        = 1'b1;
        out_ready = 1'b0;
        exp_g     = ref_grant(v, mlast);
        exp_d     = ref_widen(exp_g ? d1 : d0);
        tick();
        check("in_ready_capture", 32'(in_ready), 32'(exp_g ? 2'b10 : 2'b01));
        check("busy_capture", 32'(busy), 32'd1);
        tick();
        // Sample already captured: scribble the inputs to prove the hold.
        in_data0 = ~d0;
        in_data1 = ~d1;
        if (drop_en) en = 1'b0;
        else         in_valid = 2'b00;
        check("in_ready_scale", 32'(in_ready), 32'd0);
        check("out_valid_scale", 32'(out_valid), 32'd0);
        check("out_data_scale", 32'(out_data), 32'd0);
        tick();
        check("out_valid_out", 32'(out_valid), 32'd1);
        check("out_data_out", 32'(out_data), 32'(exp_d));
        check("out_chan_out", 32'(out_chan), 32'(exp_g));
    endtask

    task automatic finish_txn(input int stall);
        for (int i = 0; i < stall; i++) begin
            tick();
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", 32'(out_data), 32'(exp_d));
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        mlast = exp_g;
`ifdef AUDIO_SCALE_STATS_EN
        if (exp_g) mcnt1 = mcnt1 + 16'd1;
        else       mcnt0 = mcnt0 + 16'd1;
        check("cnt0", 32'(cnt0), 32'(mcnt0));
        check("cnt1", 32'(cnt1), 32'(mcnt1));
`endif
        check("out_valid_idle", 32'(out_valid), 32'd0);
        check("out_data_idle", 32'(out_data), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; in_valid = 2'b00; out_ready = 1'b0;
        in_data0 = '0; in_data1 = '0;
        mlast = 1'b1;
`ifdef AUDIO_SCALE_STATS_EN
        mcnt0 = '0; mcnt1 = '0;
`endif
        tick(); tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_chan", 32'(out_chan), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();

        // Extremes of the signed range on each channel.
        start_txn(2'b01, 16'h7FFF, 16'h0000, 1'b0); finish_txn(0);
        start_txn(2'b10, 16'h1234, 16'h8000, 1'b0); finish_txn(0);
        start_txn(2'b10, 16'h0000, 16'hFFFF, 1'b0); finish_txn(0);

        // Ties alternate.
        for (int i = 0; i < 4; i++) begin
            start_txn(2'b11, 16'(16'h0100 + i), 16'(16'h0200 + i), 1'b0);
            finish_txn(0);
        end

        // Backpressure.
        start_txn(2'b01, 16'hC001, 16'h0000, 1'b0); finish_txn(10);

        // en dropped in SCALE with both channels still requesting.
        start_txn(2'b11, 16'h1111, 16'h2222, 1'b1);
        in_valid = 2'b11;
        finish_txn(0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("en_low_in_ready", 32'(in_ready), 32'd0);
            check("en_low_busy", 32'(busy), 32'd0);
        end
        start_txn(2'b11, 16'h3333, 16'h4444, 1'b0); finish_txn(0);

        // Reset in OUT: serve ch0 so a tie would pick ch1 without the reset.
        start_txn(2'b01, 16'h0101, 16'h0000, 1'b0); finish_txn(0);
        start_txn(2'b11, 16'h0202, 16'h0303, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_data", 32'(out_data), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        mlast = 1'b1;
`ifdef AUDIO_SCALE_STATS_EN
        mcnt0 = '0; mcnt1 = '0;
`endif
        start_txn(2'b11, 16'h0A0A, 16'h0B0B, 1'b0);
        check("post_rst_grant", 32'(out_chan), 32'd0);
        finish_txn(0);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            logic [1:0] v;
            v = 2'($urandom_range(1, 3));
            start_txn(v, 16'($urandom), 16'($urandom), 1'b0);
            finish_txn(int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
